// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : pwm_bank
// Description : Bank of CHANNELS independent PWM generators on one core clock.
//               Each channel has a programmable period, set point and reset
//               point. Host writes go to a shadow set. A global load arms every
//               channel whose shadow differs from its active set. The shadow
//               is then committed glitch-free at that channel's next period
//               wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clkCore,
  input  logic                reset,
  input  logic                en,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_period,
  input  logic [WIDTH-1:0]    wr_set,
  input  logic [WIDTH-1:0]    wr_reset,
  input  logic                load,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] pwm_set,
  output logic [CHANNELS-1:0] pwm_reset,
  output logic [CHANNELS-1:0] wrap,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      localparam logic [CH_W-1:0] c_idx = CH_W'(gi);

      // Active settings (govern the waveform)
      logic [WIDTH-1:0] per_q,    per_d;
      logic [WIDTH-1:0] set_pt_q, set_pt_d;
      logic [WIDTH-1:0] rst_pt_q, rst_pt_d;
      // Shadow settings (written by the host)
      logic [WIDTH-1:0] sh_per_q,    sh_per_d;
      logic [WIDTH-1:0] sh_set_pt_q, sh_set_pt_d;
      logic [WIDTH-1:0] sh_rst_pt_q, sh_rst_pt_d;
      // Counter, commit flag and registered outputs
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic             pend_q, pend_d;
      logic             pwm_q, pwm_d;
      logic             pset_q, pset_d;
      logic             prst_q, prst_d;
      logic             wrap_q, wrap_d;

      logic w_off;
      logic w_at_end;
      logic w_commit;
      logic w_set_hit;
      logic w_rst_hit;
      logic w_wr_hit;
      logic w_differs;

      // Decode period position and which edges fire this cycle. An off
      // channel counts as wrapping every cycle so an armed commit lands at once.
      always_comb begin
        w_off     = (per_q == c_zero);
        w_at_end  = w_off || (cnt_q == (per_q - c_one));
        w_commit  = en && w_at_end && pend_q;
        w_set_hit = en && !w_off && (cnt_q == set_pt_q) && (set_pt_q < per_q);
        w_rst_hit = en && !w_off && (cnt_q == rst_pt_q) && (rst_pt_q < per_q);
        w_wr_hit  = wr_en && (wr_ch == c_idx);
      end

      // Counter advance and output level; reset match dominates set match
      always_comb begin
        cnt_d = cnt_q;
        pwm_d = pwm_q;
        if (en) begin
          cnt_d = w_at_end ? c_zero : (cnt_q + c_one);
          if (w_off) begin
            pwm_d = 1'b0;
          end else if (w_rst_hit) begin
            pwm_d = 1'b0;
          end else if (w_set_hit) begin
            pwm_d = 1'b1;
          end
        end
      end

      // Debug pulses, one cycle after the match or wrap
      always_comb begin
        pset_d = w_set_hit && !w_rst_hit;
        prst_d = w_rst_hit;
        wrap_d = en && !w_off && w_at_end;
      end

      // Active set takes the pre-write shadow at commit time
      always_comb begin
        per_d    = per_q;
        set_pt_d = set_pt_q;
        rst_pt_d = rst_pt_q;
        if (w_commit) begin
          per_d    = sh_per_q;
          set_pt_d = sh_set_pt_q;
          rst_pt_d = sh_rst_pt_q;
        end
      end

      // Shadow set is only ever touched by a host write to this channel
      always_comb begin
        sh_per_d    = sh_per_q;
        sh_set_pt_d = sh_set_pt_q;
        sh_rst_pt_d = sh_rst_pt_q;
        if (w_wr_hit) begin
          sh_per_d    = wr_period;
          sh_set_pt_d = wr_set;
          sh_rst_pt_d = wr_reset;
        end
      end

      // Pending: cleared by commit, armed by load against the post-edge values
      always_comb begin
        w_differs = (sh_per_d != per_d) || (sh_set_pt_d != set_pt_d) ||
                    (sh_rst_pt_d != rst_pt_d);
        pend_d    = (pend_q && !w_commit) || (load && w_differs);
      end

      // State registers with synchronous reset
      always_ff @(posedge clkCore) begin
        if (reset) begin
          per_q       <= '0;
          set_pt_q    <= '0;
          rst_pt_q    <= '0;
          sh_per_q    <= '0;
          sh_set_pt_q <= '0;
          sh_rst_pt_q <= '0;
          cnt_q       <= '0;
          pend_q      <= 1'b0;
          pwm_q       <= 1'b0;
          pset_q      <= 1'b0;
          prst_q      <= 1'b0;
          wrap_q      <= 1'b0;
        end else begin
          per_q       <= per_d;
          set_pt_q    <= set_pt_d;
          rst_pt_q    <= rst_pt_d;
          sh_per_q    <= sh_per_d;
          sh_set_pt_q <= sh_set_pt_d;
          sh_rst_pt_q <= sh_rst_pt_d;
          cnt_q       <= cnt_d;
          pend_q      <= pend_d;
          pwm_q       <= pwm_d;
          pset_q      <= pset_d;
          prst_q      <= prst_d;
          wrap_q      <= wrap_d;
        end
      end

      assign pwm[gi]       = pwm_q;
      assign pwm_set[gi]   = pset_q;
      assign pwm_reset[gi] = prst_q;
      assign wrap[gi]      = wrap_q;
      assign pending[gi]   = pend_q;
    end
  endgenerate

endmodule
`default_nettype wire
